sram_wb_responder: RTL and testbench



---
 rtl/sram_wb_responder_pkg.sv | 32 +++
 rtl/sram_wb_responder_if.sv | 32 +++
 rtl/sram_wb_responder.sv | 124 ++++++++++++
 tb/tb_sram_wb_responder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_wb_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_wb_responder_pkg
//  Description : Shared definitions for the SRAM Wishbone responder and the
//                benches that drive it: FSM state encoding, the full-word
//                byte-select constant and a byte-lane expansion helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_wb_responder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    // All four byte lanes selected.
    localparam logic [3:0] SELECT_WORD = 4'hF;

    // Expands a 4-bit byte select into a 32-bit bit mask (lane n -> [8n+7:8n]).
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{sel[i]}};
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_wb_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_wb_responder_if
//  Description : Single-word user-space bus between an initiator (bridge or
//                bench) and the SRAM responder.
//                master : drives wbEnable/wbWriteEnable/wbByteSelect/
//                         wbAddress/wbDataWrite, observes wbDataRead/wbBusy
//                slave  : the opposite directions
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_wb_responder_if;

    logic        wbEnable;
    logic        wbWriteEnable;
    logic [3:0]  wbByteSelect;
    logic [31:0] wbAddress;
    logic [31:0] wbDataWrite;
    logic [31:0] wbDataRead;
    logic        wbBusy;

    modport master (
        output wbEnable, wbWriteEnable, wbByteSelect, wbAddress, wbDataWrite,
        input  wbDataRead, wbBusy
    );

    modport slave (
        input  wbEnable, wbWriteEnable, wbByteSelect, wbAddress, wbDataWrite,
        output wbDataRead, wbBusy
    );

endinterface
`default_nettype wire

// File: rtl/sram_wb_responder.sv
`default_nettype none
// ============================================================================
//  Module      : sram_wb_responder
//  Description : Services single-word bus reads/writes from one single-port
//                SRAM macro with active-low controls and one-cycle read
//                latency. Supports byte-lane writes, masked reads and a
//                configurable number of wait states before each response.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                wb (slave modport)  - request/response bus
//                sramCSB/sramWEB     - active-low chip select / write enable
//                sramWMask           - byte write mask
//                sramAddress         - word address
//                sramDataWrite/Read  - macro data in/out
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_wb_responder
    import sram_wb_responder_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 9,
    parameter int WAIT_STATES   = 0
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    sram_wb_responder_if.slave            wb,
    output logic                          sramCSB,
    output logic                          sramWEB,
    output logic [3:0]                    sramWMask,
    output logic [ADDRESS_WIDTH-1:0]      sramAddress,
    output logic [31:0]                   sramDataWrite,
    input  wire logic [31:0]              sramDataRead
);

    // State reached once the SRAM access itself is done.
    localparam state_t     c_AFTER_ACCESS = (WAIT_STATES > 0) ? WAIT : RESPOND;
    localparam logic [2:0] c_WAIT_LOAD    = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_wait_cnt;
    logic [3:0]  r_read_sel;
    logic [31:0] r_data_read;
    logic        w_cmd;

    // Address bits outside the word window are decoded upstream.
    wire w_unused_addr_bits = &{1'b0, wb.wbAddress[31:ADDRESS_WIDTH+2], wb.wbAddress[1:0]};

    // The SRAM is commanded only during the IDLE cycle of a request; reset
    // overrides so the macro sees nothing while rst is high.
    assign w_cmd = (r_state == IDLE) && wb.wbEnable && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (wb.wbEnable) begin
                    w_state_next = wb.wbWriteEnable ? c_AFTER_ACCESS : READ;
                end
            end
            READ:    w_state_next = c_AFTER_ACCESS;
            WAIT: begin
                if (r_wait_cnt == 3'd0) begin
                    w_state_next = RESPOND;
                end
            end
            RESPOND: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Wait counter, captured read select and read data register.
    // The select is latched at command time so a request withdrawn early
    // still returns a consistently masked word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt  <= 3'd0;
            r_read_sel  <= 4'd0;
            r_data_read <= 32'd0;
        end else begin
            if ((w_state_next == WAIT) && (r_state != WAIT)) begin
                r_wait_cnt <= c_WAIT_LOAD;
            end else if ((r_state == WAIT) && (r_wait_cnt != 3'd0)) begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
            end

            if (w_cmd && !wb.wbWriteEnable) begin
                r_read_sel <= wb.wbByteSelect;
            end

            if (r_state == READ) begin
                r_data_read <= sramDataRead & lane_mask(r_read_sel);
            end
        end
    end

    always_comb begin
        sramCSB       = 1'b1;
        sramWEB       = 1'b1;
        sramWMask     = 4'd0;
        sramAddress   = '0;
        sramDataWrite = 32'd0;
        if (w_cmd) begin
            sramCSB       = 1'b0;
            sramWEB       = !wb.wbWriteEnable;
            sramWMask     = wb.wbWriteEnable ? wb.wbByteSelect : 4'd0;
            sramAddress   = wb.wbAddress[ADDRESS_WIDTH+1:2];
            sramDataWrite = wb.wbDataWrite;
        end
    end

    // During reset the state may still read RESPOND for this cycle, so busy
    // simply follows the request.
    assign wb.wbBusy     = wb.wbEnable && (rst || (r_state != RESPOND));
    assign wb.wbDataRead = r_data_read;

endmodule
`default_nettype wire

// File: tb/tb_sram_wb_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_wb_responder
//  Description : Bench for sram_wb_responder. Two instances (0 and 3 wait
//                states) share one stimulus bus, each with its own SRAM
//                model; a word-array reference model supplies expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_wb_responder;
    import sram_wb_responder_pkg::*;

    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared stimulus, steered to one instance by r_dut.
    logic        r_en    = 1'b0;
    logic        r_we    = 1'b0;
    logic [3:0]  r_sel   = 4'd0;
    logic [31:0] r_addr  = 32'd0;
    logic [31:0] r_wdata = 32'd0;
    int          r_dut   = 0;

    sram_wb_responder_if wb0 ();
    sram_wb_responder_if wb1 ();

    assign wb0.wbEnable      = r_en && (r_dut == 0);
    assign wb0.wbWriteEnable = r_we;
    assign wb0.wbByteSelect  = r_sel;
    assign wb0.wbAddress     = r_addr;
    assign wb0.wbDataWrite   = r_wdata;
    assign wb1.wbEnable      = r_en && (r_dut == 1);
    assign wb1.wbWriteEnable = r_we;
    assign wb1.wbByteSelect  = r_sel;
    assign wb1.wbAddress     = r_addr;
    assign wb1.wbDataWrite   = r_wdata;

    logic          csb0, web0, csb1, web1;
    logic [3:0]    wm0, wm1;
    logic [AW-1:0] ad0, ad1;
    logic [31:0]   dw0, dw1;
    logic [31:0]   dout0 = 32'd0;
    logic [31:0]   dout1 = 32'd0;

    sram_wb_responder #(.ADDRESS_WIDTH(AW), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .wb(wb0),
        .sramCSB(csb0), .sramWEB(web0), .sramWMask(wm0), .sramAddress(ad0),
        .sramDataWrite(dw0), .sramDataRead(dout0)
    );

    sram_wb_responder #(.ADDRESS_WIDTH(AW), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .rst(rst), .wb(wb1),
        .sramCSB(csb1), .sramWEB(web1), .sramWMask(wm1), .sramAddress(ad1),
        .sramDataWrite(dw1), .sramDataRead(dout1)
    );

    // Single-port SRAM macros: masked write or read on the command edge.
    logic [31:0] mem0 [DEPTH];
    logic [31:0] mem1 [DEPTH];

    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++)
                    if (wm0[b]) mem0[ad0][8*b +: 8] <= dw0[8*b +: 8];
            end else begin
                dout0 <= mem0[ad0];
            end
        end
    end

    always @(posedge clk) begin
        if (!csb1) begin
            if (!web1) begin
                for (int b = 0; b < 4; b++)
                    if (wm1[b]) mem1[ad1][8*b +: 8] <= dw1[8*b +: 8];
            end else begin
                dout1 <= mem1[ad1];
            end
        end
    end

    wire        s_busy  = (r_dut == 1) ? wb1.wbBusy     : wb0.wbBusy;
    wire [31:0] s_rdata = (r_dut == 1) ? wb1.wbDataRead : wb0.wbDataRead;
    wire        s_csb   = (r_dut == 1) ? csb1           : csb0;

    // Reference model: word contents and last delivered read word per instance.
    logic [31:0] exp_mem [2][DEPTH];
    logic [31:0] exp_last [2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] expand(input logic [3:0] s);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 4; i++)
            if (s[i]) m = m | (32'hFF << (8 * i));
        return m;
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // One transaction: request driven just after an edge, responses sampled
    // on falling edges; busy cycles and chip-select pulses are counted.
    task automatic txn(input int d, input bit we, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] data,
                       input bit hold, output int resp_cyc);
        int lat, lows, idx;
        logic [31:0] exp_d;
        @(posedge clk); #1;
        r_dut = d; r_we = we; r_sel = sel; r_addr = addr; r_wdata = data; r_en = 1'b1;
        idx = word_of(addr);
        if (we) begin
            for (int i = 0; i < 4; i++)
                if (sel[i]) exp_mem[d][idx][8*i +: 8] = data[8*i +: 8];
            exp_d = exp_last[d];
        end else begin
            exp_d = exp_mem[d][idx] & expand(sel);
            exp_last[d] = exp_d;
        end
        lat = 0; lows = 0;
        forever begin
            @(negedge clk);
            if (!s_csb) lows++;
            if (!s_busy) break;
            lat++;
            if (lat > 40) begin
                check("response_timeout", 32'(lat), 32'd0);
                break;
            end
        end
        resp_cyc = cyc;
        check(we ? "wr_latency" : "rd_latency", 32'(lat), 32'((we ? 1 : 2) + ws_of(d)));
        check("csb_pulses", 32'(lows), 32'd1);
        check(we ? "wr_keeps_rdata" : "rd_data", s_rdata, exp_d);
        if (!hold) r_en = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c1, c2, lat, idx;
        logic [31:0] a;

        for (int i = 0; i < DEPTH; i++) begin
            mem0[i] = 32'd0; mem1[i] = 32'd0;
            exp_mem[0][i] = 32'd0; exp_mem[1][i] = 32'd0;
        end
        exp_last[0] = 32'd0; exp_last[1] = 32'd0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdata0", wb0.wbDataRead, 32'd0);
        check("rst_rdata1", wb1.wbDataRead, 32'd0);
        check("rst_ctrl0", {31'd0, csb0 & web0}, 32'd1);
        check("rst_mask_addr0", {19'd0, wm0, ad0}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // Write then read, no wait states
        txn(0, 1'b1, SELECT_WORD, 32'h40 << 2, 32'hDEADBEEF, 1'b0, c1);
        txn(0, 1'b0, SELECT_WORD, 32'h40 << 2, 32'd0, 1'b0, c1);
        check("wr_rd_value", s_rdata, 32'hDEADBEEF);

        // Byte lanes
        txn(0, 1'b1, SELECT_WORD, 32'h10 << 2, 32'h11223344, 1'b0, c1);
        txn(0, 1'b1, 4'b0101,     32'h10 << 2, 32'hAABBCCDD, 1'b0, c1);
        txn(0, 1'b0, SELECT_WORD, 32'h10 << 2, 32'd0, 1'b0, c1);
        check("lanes_full", s_rdata, 32'h11BB33DD);
        txn(0, 1'b0, 4'b0011,     32'h10 << 2, 32'd0, 1'b0, c1);
        check("lanes_low", s_rdata, 32'h000033DD);

        // Three wait states
        txn(1, 1'b1, SELECT_WORD, 32'h42 << 2, 32'hCAFEF00D, 1'b0, c1);
        txn(1, 1'b0, SELECT_WORD, 32'h42 << 2, 32'd0, 1'b0, c1);
        check("ws3_value", s_rdata, 32'hCAFEF00D);

        // Held request across two reads
        txn(0, 1'b1, SELECT_WORD, 32'h00 << 2, 32'h01020304, 1'b0, c1);
        txn(0, 1'b1, SELECT_WORD, 32'h41 << 2, 32'h0A0B0C0D, 1'b0, c1);
        txn(0, 1'b0, SELECT_WORD, 32'h00 << 2, 32'd0, 1'b1, c1);
        txn(0, 1'b0, SELECT_WORD, 32'h41 << 2, 32'd0, 1'b0, c2);
        check("b2b_gap", 32'(c2 - c1), 32'd3);

        // Reset while in READ, request held through it
        @(posedge clk); #1;
        r_dut = 0; r_we = 1'b0; r_sel = SELECT_WORD; r_addr = 32'h41 << 2; r_en = 1'b1;
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        check("rst_busy_follows_en", {31'd0, s_busy}, 32'd1);
        check("rst_sram_idle", {31'd0, csb0 & web0}, 32'd1);
        check("rst_sram_zero", {19'd0, wm0, ad0} | dw0, 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        exp_last[0] = 32'd0; exp_last[1] = 32'd0;
        @(negedge clk);
        check("rst_mid_rdata", s_rdata, 32'd0);
        check("restart_cmd", {31'd0, s_csb}, 32'd0);
        lat = 1;
        forever begin
            @(negedge clk);
            if (!s_busy) break;
            lat++;
            if (lat > 40) begin check("restart_timeout", 32'(lat), 32'd0); break; end
        end
        check("restart_latency", 32'(lat), 32'd2);
        exp_last[0] = exp_mem[0][32'h41];
        check("restart_data", s_rdata, exp_last[0]);
        r_en = 1'b0;

        // Write with no lanes selected
        txn(0, 1'b1, SELECT_WORD, 32'h55 << 2, 32'h12345678, 1'b0, c1);
        txn(0, 1'b1, 4'h0,        32'h55 << 2, 32'hFFFFFFFF, 1'b0, c1);
        txn(0, 1'b0, SELECT_WORD, 32'h55 << 2, 32'd0, 1'b0, c1);
        check("sel0_untouched", s_rdata, 32'h12345678);

        // Address aliasing every 2 KiB
        txn(0, 1'b1, SELECT_WORD, 32'h0003_5980, 32'h5A5A1234, 1'b0, c1);
        txn(0, 1'b0, SELECT_WORD, 32'h0000_0982, 32'd0, 1'b0, c1);
        check("alias_value", s_rdata, 32'h5A5A1234);

        // Request withdrawn early on the wait-state instance
        @(posedge clk); #1;
        r_dut = 1; r_we = 1'b0; r_sel = 4'b1010; r_addr = 32'h42 << 2; r_en = 1'b1;
        exp_last[1] = exp_mem[1][32'h42] & expand(4'b1010);
        @(posedge clk); #1; r_en = 1'b0; r_sel = 4'b0000;
        @(negedge clk);
        check("abort_busy_low", {31'd0, s_busy}, 32'd0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("abort_captured", s_rdata, exp_last[1]);
        txn(1, 1'b0, SELECT_WORD, 32'h42 << 2, 32'd0, 1'b0, c1);

        // Randomized traffic on both instances
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 60; i++) begin
                a = $urandom;
                idx = int'($urandom_range(0, 15));
                a[10:2] = 9'(idx);
                txn(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom,
                    (i < 59) ? 1'($urandom_range(0, 1)) : 1'b0, c1);
            end
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
